tlc5955_receiver: RTL and testbench

TLC5955_RECEIVER -- requirements
Module: tlc5955_receiver

---
 rtl/tlc5955_receiver_pkg.sv | 10 +
 rtl/tlc5955_receiver_rx_device.sv | 45 ++++
 rtl/tlc5955_receiver.sv | 146 ++++++++++++++
 tb/tb_tlc5955_receiver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc5955_receiver_pkg.sv
// Shared TLC5955 frame geometry, used by the receiver RTL and by the controller's benches.
package tlc5955_receiver_pkg;
    localparam int              GsBits    = 768;
    localparam int              FrameBits = 769;
    localparam int              CfgBits   = 384;
    localparam int              WordBits  = 16;
    localparam int              GsWords   = 48;
    localparam int              CfgWords  = 24;
    localparam logic [7:0]      CfgHeader = 8'h96;
endpackage

// File: rtl/tlc5955_receiver_rx_device.sv
// One emulated TLC5955: 769-bit shift slice plus GS and config latches.
// Latency: shift/load take effect on the enabling clk edge; backpressure: none, strobes are always accepted.
module tlc5955_rx_device
    import tlc5955_receiver_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_shift_en,
    input  logic               i_shift_in,
    input  logic               i_gs_load,
    input  logic               i_cfg_load,
    output logic               o_shift_out,
    output logic               o_select,
    output logic               o_header_ok,
    output logic [GsBits-1:0]  o_gs_latch,
    output logic [CfgBits-1:0] o_cfg_latch
);

    logic [FrameBits-1:0] r_shift;
    logic [GsBits-1:0]    r_gs_latch;
    logic [CfgBits-1:0]   r_cfg_latch;

    // Loads never coincide with a shift, so both latches capture the settled frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_gs_latch  <= '0;
            r_cfg_latch <= '0;
        end else begin
            if (i_shift_en)
                r_shift <= {r_shift[FrameBits-2:0], i_shift_in};
            if (i_gs_load)
                r_gs_latch <= r_shift[GsBits-1:0];
            if (i_cfg_load)
                r_cfg_latch <= r_shift[CfgBits-1:0];
        end
    end

    assign o_shift_out = r_shift[FrameBits-1];
    assign o_select    = r_shift[GsBits];
    assign o_header_ok = (r_shift[GsBits-1 -: 8] == CfgHeader);
    assign o_gs_latch  = r_gs_latch;
    assign o_cfg_latch = r_cfg_latch;

endmodule

// File: rtl/tlc5955_receiver.sv
// TLC5955 daisy-chain receiver: serial shift, GS/config latching, event pulses and word readback.
// Latency: pulses and read_data 1 cycle after the triggering edge; backpressure: none, strobes are never stalled.
module tlc5955_receiver
    import tlc5955_receiver_pkg::*;
#(
    parameter int DaisyChain = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        lat,
    output logic        miso,
    output logic        gs_latched,
    output logic        cfg_latched,
    output logic        frame_error,
    output logic [15:0] gs_count,
    output logic [15:0] cfg_count,
    input  logic        read_cfg,
    input  logic [15:0] read_addr,
    output logic [15:0] read_data
);

    localparam int             ChainBits = FrameBits * DaisyChain;
    localparam int             CntW      = $clog2(ChainBits + 2);
    localparam logic [CntW-1:0] CntFull  = CntW'(ChainBits);
    localparam logic [CntW-1:0] CntSat   = CntW'(ChainBits + 1);

    logic            r_sclk_q;
    logic            r_lat_q;
    logic [CntW-1:0] r_bit_cnt;
    logic            r_gs_latched;
    logic            r_cfg_latched;
    logic            r_frame_error;
    logic [15:0]     r_gs_count;
    logic [15:0]     r_cfg_count;
    logic [15:0]     r_read_data;

    logic                  w_sclk_rise;
    logic                  w_lat_rise;
    logic                  w_sclk_bad;
    logic                  w_shift_en;
    logic                  w_lat_ok;
    logic                  w_gs_load;
    logic                  w_cfg_load;
    logic                  w_lat_bad;
    logic [DaisyChain:0]   w_chain;
    logic [DaisyChain-1:0] w_select;
    logic [DaisyChain-1:0] w_header_ok;
    logic [DaisyChain-1:0] w_gs_hit;
    logic [DaisyChain-1:0] w_cfg_hit;
    logic [GsBits-1:0]     w_gs_latch  [DaisyChain];
    logic [CfgBits-1:0]    w_cfg_latch [DaisyChain];
    logic [5:0]            w_gs_idx    [DaisyChain];
    logic [4:0]            w_cfg_idx   [DaisyChain];
    logic [15:0]           w_gs_word   [DaisyChain];
    logic [15:0]           w_cfg_word  [DaisyChain];
    logic [15:0]           w_read_next;

    assign w_sclk_rise = sclk & ~r_sclk_q;
    assign w_lat_rise  = lat & ~r_lat_q;
    // A clock edge coinciding with a latch edge is rejected so the latch sees the pre-edge frame.
    assign w_sclk_bad  = w_sclk_rise & (r_lat_q | w_lat_rise);
    assign w_shift_en  = w_sclk_rise & ~w_sclk_bad;

    assign w_lat_ok   = w_lat_rise && (r_bit_cnt == CntFull);
    assign w_gs_load  = w_lat_ok && ~|w_select;
    assign w_cfg_load = w_lat_ok && (&w_select) && (&w_header_ok);
    assign w_lat_bad  = w_lat_rise && !w_gs_load && !w_cfg_load;

    assign w_chain[0] = mosi;

    for (genvar g = 0; g < DaisyChain; g++) begin : g_dev
        tlc5955_rx_device u_dev (
            .clk         (clk),
            .reset       (reset),
            .i_shift_en  (w_shift_en),
            .i_shift_in  (w_chain[g]),
            .i_gs_load   (w_gs_load),
            .i_cfg_load  (w_cfg_load),
            .o_shift_out (w_chain[g+1]),
            .o_select    (w_select[g]),
            .o_header_ok (w_header_ok[g]),
            .o_gs_latch  (w_gs_latch[g]),
            .o_cfg_latch (w_cfg_latch[g])
        );

        // Each device owns a contiguous address window; the index is zeroed outside it.
        assign w_gs_hit[g]  = !read_cfg && (read_addr >= 16'(g * GsWords))
                              && (read_addr < 16'((g + 1) * GsWords));
        assign w_cfg_hit[g] = read_cfg && (read_addr >= 16'(g * CfgWords))
                              && (read_addr < 16'((g + 1) * CfgWords));
        assign w_gs_idx[g]  = w_gs_hit[g]  ? 6'(read_addr - 16'(g * GsWords))  : 6'd0;
        assign w_cfg_idx[g] = w_cfg_hit[g] ? 5'(read_addr - 16'(g * CfgWords)) : 5'd0;
        assign w_gs_word[g]  = w_gs_latch[g][{w_gs_idx[g], 4'b0000} +: WordBits];
        assign w_cfg_word[g] = w_cfg_latch[g][{w_cfg_idx[g], 4'b0000} +: WordBits];
    end

    always_comb begin
        w_read_next = '0;
        for (int d = 0; d < DaisyChain; d++) begin
            if (w_gs_hit[d])
                w_read_next = w_gs_word[d];
            if (w_cfg_hit[d])
                w_read_next = w_cfg_word[d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_q      <= 1'b0;
            r_lat_q       <= 1'b0;
            r_bit_cnt     <= '0;
            r_gs_latched  <= 1'b0;
            r_cfg_latched <= 1'b0;
            r_frame_error <= 1'b0;
            r_gs_count    <= '0;
            r_cfg_count   <= '0;
            r_read_data   <= '0;
        end else begin
            r_sclk_q <= sclk;
            r_lat_q  <= lat;
            if (w_lat_rise)
                r_bit_cnt <= '0;
            else if (w_shift_en && (r_bit_cnt != CntSat))
                r_bit_cnt <= r_bit_cnt + 1'b1;
            r_gs_latched  <= w_gs_load;
            r_cfg_latched <= w_cfg_load;
            r_frame_error <= w_lat_bad | w_sclk_bad;
            if (w_gs_load)
                r_gs_count <= r_gs_count + 16'd1;
            if (w_cfg_load)
                r_cfg_count <= r_cfg_count + 16'd1;
            r_read_data <= w_read_next;
        end
    end

    assign miso        = w_chain[DaisyChain];
    assign gs_latched  = r_gs_latched;
    assign cfg_latched = r_cfg_latched;
    assign frame_error = r_frame_error;
    assign gs_count    = r_gs_count;
    assign cfg_count   = r_cfg_count;
    assign read_data   = r_read_data;

endmodule

// File: tb/tb_tlc5955_receiver.sv
// Bench for tlc5955_receiver: a single-device and a two-device chain driven from one serial stream.
module tb_tlc5955_receiver;
    import tlc5955_receiver_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sclk, mosi, lat, read_cfg;
    logic [15:0] read_addr;
    logic [1:0]  miso_o, gsl_o, cfgl_o, ferr_o;
    logic [15:0] gsc_o [2];
    logic [15:0] cfgc_o[2];
    logic [15:0] rd_o  [2];

    always #5 clk = ~clk;

    tlc5955_receiver #(.DaisyChain(1)) u_dut1 (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .lat(lat),
        .miso(miso_o[0]), .gs_latched(gsl_o[0]), .cfg_latched(cfgl_o[0]),
        .frame_error(ferr_o[0]), .gs_count(gsc_o[0]), .cfg_count(cfgc_o[0]),
        .read_cfg(read_cfg), .read_addr(read_addr), .read_data(rd_o[0]));

    tlc5955_receiver #(.DaisyChain(2)) u_dut2 (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .lat(lat),
        .miso(miso_o[1]), .gs_latched(gsl_o[1]), .cfg_latched(cfgl_o[1]),
        .frame_error(ferr_o[1]), .gs_count(gsc_o[1]), .cfg_count(cfgc_o[1]),
        .read_cfg(read_cfg), .read_addr(read_addr), .read_data(rd_o[1]));

    // Reference model: accepted bits since reset (newest last), bit count since last latch edge.
    bit          hist[$];
    int          m_cnt;
    logic [15:0] m_gs  [2][96];
    logic [15:0] m_cfg [2][48];
    logic [15:0] m_gsc [2];
    logic [15:0] m_cfgc[2];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          cfg;
        logic [15:0] addr;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[10];

    function automatic bit mbit(int j);
        if (j < hist.size()) return hist[hist.size() - 1 - j];
        return 1'b0;
    endfunction

    function automatic logic [15:0] mword(int base);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = mbit(base + i);
        return w;
    endfunction

    function automatic logic [15:0] m_read(int k, bit cfg, logic [15:0] addr);
        if (!cfg) return (int'(addr) < GsWords * (k + 1)) ? m_gs[k][addr] : 16'h0;
        return (int'(addr) < CfgWords * (k + 1)) ? m_cfg[k][addr] : 16'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        hist.delete();
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_gsc[k] = 0;
            m_cfgc[k] = 0;
            for (int i = 0; i < 96; i++) m_gs[k][i] = 0;
            for (int i = 0; i < 48; i++) m_cfg[k][i] = 0;
        end
    endtask

    task automatic model_lat(output logic [1:0] eg, output logic [1:0] ec, output logic [1:0] ee);
        int       n;
        bit       all0, all1, hdr_ok;
        logic [7:0] h;
        eg = 0; ec = 0; ee = 0;
        for (int k = 0; k < 2; k++) begin
            n = k + 1;
            if (m_cnt != FrameBits * n) begin
                ee[k] = 1'b1;
            end else begin
                all0 = 1; all1 = 1; hdr_ok = 1;
                for (int d = 0; d < n; d++) begin
                    if (mbit(d * FrameBits + GsBits)) all0 = 0; else all1 = 0;
                    for (int i = 0; i < 8; i++) h[i] = mbit(d * FrameBits + 760 + i);
                    if (h != CfgHeader) hdr_ok = 0;
                end
                if (all0) begin
                    eg[k] = 1'b1;
                    m_gsc[k] = m_gsc[k] + 16'd1;
                    for (int d = 0; d < n; d++)
                        for (int c = 0; c < GsWords; c++)
                            m_gs[k][d * GsWords + c] = mword(d * FrameBits + 16 * c);
                end else if (all1 && hdr_ok) begin
                    ec[k] = 1'b1;
                    m_cfgc[k] = m_cfgc[k] + 16'd1;
                    for (int d = 0; d < n; d++)
                        for (int c = 0; c < CfgWords; c++)
                            m_cfg[k][d * CfgWords + c] = mword(d * FrameBits + 16 * c);
                end else begin
                    ee[k] = 1'b1;
                end
            end
        end
        m_cnt = 0;
    endtask

    task automatic do_reset;
        reset = 1; sclk = 0; lat = 0; mosi = 0;
        tick;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_miso[%0d]", k), miso_o[k], 0);
            chk($sformatf("rst_pulses[%0d]", k), {gsl_o[k], cfgl_o[k], ferr_o[k]}, 0);
            chk($sformatf("rst_counts[%0d]", k), {gsc_o[k], cfgc_o[k]}, 0);
            chk($sformatf("rst_rdata[%0d]", k), rd_o[k], 0);
        end
        reset = 0;
    endtask

    task automatic send_bit(input bit b);
        mosi = b; sclk = 0;
        tick;
        sclk = 1;
        tick;
        hist.push_back(b);
        if (hist.size() > 2 * FrameBits) void'(hist.pop_front());
        m_cnt++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("miso[%0d]", k), miso_o[k], m_miso(k));
            chk($sformatf("bit_ferr[%0d]", k), ferr_o[k], 0);
        end
    endtask

    function automatic bit m_miso(int k);
        return mbit(FrameBits * (k + 1) - 1);
    endfunction

    task automatic send_frame(input logic [1537:0] fr, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_bit(fr[i]);
    endtask

    task automatic release_lat;
        lat = 0; sclk = 0;
        tick;
        for (int k = 0; k < 2; k++)
            chk($sformatf("pulse_end[%0d]", k), {gsl_o[k], cfgl_o[k], ferr_o[k]}, 0);
    endtask

    task automatic do_lat(input bit hold, input bit with_sclk);
        logic [1:0] eg, ec, ee;
        sclk = 0;
        tick;
        lat = 1;
        if (with_sclk) begin sclk = 1; mosi = ~mosi; end
        tick;
        model_lat(eg, ec, ee);
        if (with_sclk) ee = 2'b11;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gs_latched[%0d]", k), gsl_o[k], eg[k]);
            chk($sformatf("cfg_latched[%0d]", k), cfgl_o[k], ec[k]);
            chk($sformatf("frame_error[%0d]", k), ferr_o[k], ee[k]);
            chk($sformatf("gs_count[%0d]", k), gsc_o[k], m_gsc[k]);
            chk($sformatf("cfg_count[%0d]", k), cfgc_o[k], m_cfgc[k]);
            chk($sformatf("lat_miso[%0d]", k), miso_o[k], m_miso(k));
        end
        if (!hold) release_lat();
    endtask

    task automatic bad_sclk;
        sclk = 0;
        tick;
        sclk = 1; mosi = ~mosi;
        tick;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ign_ferr[%0d]", k), ferr_o[k], 1);
            chk($sformatf("ign_miso[%0d]", k), miso_o[k], m_miso(k));
        end
        sclk = 0;
        tick;
        for (int k = 0; k < 2; k++) chk($sformatf("ign_ferr_end[%0d]", k), ferr_o[k], 0);
    endtask

    task automatic rd(input bit cfg, input logic [15:0] addr);
        read_cfg = cfg; read_addr = addr;
        tick;
        for (int k = 0; k < 2; k++)
            chk($sformatf("rdata[%0d] cfg=%0d a=%0d", k, cfg, addr), rd_o[k], m_read(k, cfg, addr));
    endtask

    function automatic logic [1537:0] gs_frame(int n, logic [15:0] base);
        logic [1537:0] fr = '0;
        for (int d = 0; d < n; d++)
            for (int c = 0; c < GsWords; c++)
                fr[d * FrameBits + 16 * c +: 16] = base + 16'(d * 256 + c);
        return fr;
    endfunction

    function automatic logic [1537:0] cfg_frame(int n, logic [15:0] base, logic [7:0] hdr);
        logic [1537:0] fr = '0;
        for (int d = 0; d < n; d++) begin
            fr[d * FrameBits + GsBits] = 1'b1;
            fr[d * FrameBits + 760 +: 8] = hdr;
            for (int c = 0; c < CfgWords; c++)
                fr[d * FrameBits + 16 * c +: 16] = base + 16'(d * 256 + c);
        end
        return fr;
    endfunction

    initial begin
        logic [1537:0] fr;
        int            kind, n, nb;
        reset = 1; sclk = 0; mosi = 0; lat = 0; read_cfg = 0; read_addr = 0;
        tbl[0] = '{0, 16'd5,    16'h1005};
        tbl[1] = '{0, 16'd0,    16'h1000};
        tbl[2] = '{0, 16'd47,   16'h102F};
        tbl[3] = '{1, 16'd23,   16'hA517};
        tbl[4] = '{1, 16'd0,    16'hA500};
        tbl[5] = '{1, 16'd11,   16'hA50B};
        tbl[6] = '{0, 16'd48,   16'h0000};
        tbl[7] = '{1, 16'd24,   16'h0000};
        tbl[8] = '{0, 16'hFFFF, 16'h0000};
        tbl[9] = '{1, 16'hFFFF, 16'h0000};

        do_reset();

        // GS frame, config frame, then a config frame with a bad header.
        send_frame(gs_frame(1, 16'h1000), FrameBits);
        do_lat(0, 0);
        chk("gs_count_first", gsc_o[0], 1);
        rd(0, 16'd5);
        chk("gs_read_addr5", rd_o[0], 16'h1005);
        send_frame(cfg_frame(1, 16'hA500, 8'h96), FrameBits);
        do_lat(0, 0);
        send_frame(cfg_frame(1, 16'h5A00, 8'h95), FrameBits);
        do_lat(0, 0);
        chk("cfg_count_badhdr", cfgc_o[0], 1);
        for (int i = 0; i < 10; i++) begin
            read_cfg = tbl[i].cfg; read_addr = tbl[i].addr;
            tick;
            chk($sformatf("tbl[%0d]", i), rd_o[0], tbl[i].exp);
        end

        // Short frame rejected, following full frame accepted.
        send_frame(gs_frame(1, 16'h2000), GsBits);
        do_lat(0, 0);
        send_frame(gs_frame(1, 16'h3000), FrameBits);
        do_lat(0, 0);
        rd(0, 16'd7);
        chk("gs_after_short", rd_o[0], 16'h3007);

        // sclk on the latch edge and while latch is held high must neither shift nor count.
        send_frame(gs_frame(1, 16'h4000), FrameBits);
        do_lat(1, 1);
        bad_sclk();
        bad_sclk();
        release_lat();
        send_frame(gs_frame(1, 16'h4100), FrameBits - 2);
        do_lat(0, 0);

        // Two-device chain, back-to-back frames.
        do_reset();
        send_frame(gs_frame(2, 16'h1000), 2 * FrameBits);
        do_lat(0, 0);
        rd(0, 16'd48);
        chk("chain_dev1_w0_a", rd_o[1], 16'h1100);
        send_frame(gs_frame(2, 16'h6000), 2 * FrameBits);
        do_lat(0, 0);
        rd(0, 16'd48);
        chk("chain_dev1_w0_b", rd_o[1], 16'h6100);
        rd(0, 16'd47);

        // Reset in the middle of a frame.
        do_reset();
        fr = gs_frame(1, 16'h7000);
        for (int i = FrameBits - 1; i >= FrameBits - 400; i--) send_bit(fr[i]);
        do_reset();
        send_frame(fr, FrameBits);
        do_lat(0, 0);
        chk("midreset_gs_count", gsc_o[0], 1);

        // Randomized frames checked against the model.
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 4);
            n    = $urandom_range(1, 2);
            nb   = FrameBits * n;
            case (kind)
                0: fr = gs_frame(n, 16'($urandom));
                1: fr = cfg_frame(n, 16'($urandom), ($urandom_range(0, 1) != 0) ? 8'h96 : 8'($urandom));
                2: begin
                    fr = cfg_frame(2, 16'($urandom), 8'h96);
                    fr[GsBits] = 1'b0;
                    nb = 2 * FrameBits;
                end
                default: begin
                    for (int i = 0; i < 1538; i++) fr[i] = 1'($urandom_range(0, 1));
                    nb = (kind == 3) ? FrameBits : $urandom_range(760, 780);
                end
            endcase
            send_frame(fr, nb);
            do_lat(0, 0);
            for (int r = 0; r < 3; r++) rd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 100)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
